// File: rtl/vector_reverse_stream.sv
// Valid/ready word permuter: pass, full bit reverse, group-order reverse or in-group bit reverse,
// with a registered output and a skid entry. Define VECTOR_REVERSE_PARITY_EN to add out_parity.
module vector_reverse_stream #(
   parameter int WIDTH = 32,
   parameter int GRP   = 8
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
`ifdef VECTOR_REVERSE_PARITY_EN
   output logic             out_parity,
`endif
   output logic [1:0]       out_mode
);

   localparam int G = (GRP > 0) ? WIDTH / GRP : 1;

   if (WIDTH < 2 || GRP < 1 || (WIDTH % GRP) != 0) begin : g_param_check
      $error("vector_reverse_stream: WIDTH must be >= 2 and a multiple of GRP");
   end

   logic [WIDTH-1:0] rev_all;
   logic [WIDTH-1:0] grp_swap;
   logic [WIDTH-1:0] grp_rev;
   logic [WIDTH-1:0] perm_data;

   for (genvar i = 0; i < WIDTH; i++) begin : g_rev_all
      assign rev_all[i] = in_data[WIDTH-1-i];
   end

   for (genvar k = 0; k < G; k++) begin : g_grp
      for (genvar b = 0; b < GRP; b++) begin : g_bit
         assign grp_swap[k*GRP+b] = in_data[(G-1-k)*GRP+b];
         assign grp_rev[k*GRP+b]  = in_data[k*GRP+GRP-1-b];
      end
   end

   always_comb begin
      perm_data = in_data;
      case (in_mode)
         2'b01:   perm_data = rev_all;
         2'b10:   perm_data = grp_swap;
         2'b11:   perm_data = grp_rev;
         default: perm_data = in_data;
      endcase
   end

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic [1:0]       skid_mode;
   logic             accept;
   logic             out_free;

   assign in_ready = !skid_valid;
   assign accept   = in_valid && in_ready;
   assign out_free = !out_valid || out_ready;

`ifdef VECTOR_REVERSE_PARITY_EN
   logic skid_parity;
`endif

   // A non-empty skid forces in_ready low, so accept and skid drain never coincide.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         out_mode   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_mode  <= '0;
`ifdef VECTOR_REVERSE_PARITY_EN
         out_parity  <= 1'b0;
         skid_parity <= 1'b0;
`endif
      end else if (out_free) begin
         if (skid_valid) begin
            out_valid  <= 1'b1;
            out_data   <= skid_data;
            out_mode   <= skid_mode;
            skid_valid <= 1'b0;
`ifdef VECTOR_REVERSE_PARITY_EN
            out_parity <= skid_parity;
`endif
         end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= perm_data;
            out_mode  <= in_mode;
`ifdef VECTOR_REVERSE_PARITY_EN
            out_parity <= ^perm_data;
`endif
         end else begin
            out_valid <= 1'b0;
         end
      end else if (accept) begin
         skid_valid <= 1'b1;
         skid_data  <= perm_data;
         skid_mode  <= in_mode;
`ifdef VECTOR_REVERSE_PARITY_EN
         skid_parity <= ^perm_data;
`endif
      end
   end

endmodule

// File: tb/tb_vector_reverse_stream.sv
// Scoreboard bench for vector_reverse_stream (8-bit/GRP 4 main instance, 32-bit/GRP 8 sweep instance).
module tb_vector_reverse_stream;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] in_data = '0;
   logic [1:0] in_mode = '0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] out_data;
   logic [1:0] out_mode;
`ifdef VECTOR_REVERSE_PARITY_EN
   logic       out_parity;
   logic       p32;
`endif

   logic        in_valid32 = 1'b0;
   logic        in_ready32;
   logic [31:0] in_data32 = '0;
   logic [1:0]  in_mode32 = '0;
   logic        out_valid32;
   logic [31:0] out_data32;
   logic [1:0]  out_mode32;

   int total = 0;
   int bad = 0;
   int acc_cnt = 0;
   int out_cnt = 0;
   logic [9:0] exp_q[$];
   logic       prev_stall = 1'b0;
   logic [9:0] prev_word = '0;

   always #5 clk = ~clk;

   vector_reverse_stream #(.WIDTH(8), .GRP(4)) dut (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef VECTOR_REVERSE_PARITY_EN
      .out_parity(out_parity),
`endif
      .out_mode(out_mode)
   );

   vector_reverse_stream #(.WIDTH(32), .GRP(8)) dut32 (
      .clk(clk), .resetn(resetn),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_data(in_data32), .in_mode(in_mode32),
      .out_valid(out_valid32), .out_ready(1'b1), .out_data(out_data32),
`ifdef VECTOR_REVERSE_PARITY_EN
      .out_parity(p32),
`endif
      .out_mode(out_mode32)
   );

   // Reference permutation for WIDTH=8, GRP=4; returns {mode, data}.
   function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] m);
      logic [7:0] r;
      case (m)
         2'b01:   r = {d[0], d[1], d[2], d[3], d[4], d[5], d[6], d[7]};
         2'b10:   r = {d[3:0], d[7:4]};
         2'b11:   r = {d[4], d[5], d[6], d[7], d[0], d[1], d[2], d[3]};
         default: r = d;
      endcase
      return {m, r};
   endfunction

   // Inputs only change #1 after posedge, so negedge sees what the next edge will transfer.
   always @(negedge clk) begin
      if (!resetn) begin
         exp_q.delete();
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            total++;
            if ({out_mode, out_data} !== prev_word) begin
               bad++;
               $display("FAIL stall_hold: got %h required %h", {out_mode, out_data}, prev_word);
            end
         end
         if (out_valid && out_ready) begin
            total++;
            out_cnt++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL sb_underflow: got %h required none", {out_mode, out_data});
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               if ({out_mode, out_data} !== e) begin
                  bad++;
                  $display("FAIL sb_data: got %h required %h", {out_mode, out_data}, e);
               end
`ifdef VECTOR_REVERSE_PARITY_EN
               total++;
               if (out_parity !== ^e[7:0]) begin
                  bad++;
                  $display("FAIL sb_parity: got %b required %b", out_parity, ^e[7:0]);
               end
`endif
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_data, in_mode));
            acc_cnt++;
         end
         prev_stall <= out_valid && !out_ready;
         prev_word  <= {out_mode, out_data};
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_mode = 2'b01; out_ready = 1'b1;
      repeat (3) step();
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, out_data, out_mode} !== {1'b0, 1'b1, 8'h00, 2'b00}) begin
         bad++;
         $display("FAIL reset_state: got v=%b r=%b d=%h m=%h required v=0 r=1 d=00 m=0",
                  out_valid, in_ready, out_data, out_mode);
      end
      @(posedge clk); #1;
      resetn = 1'b1; in_valid = 1'b0;
      step();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_discard: got v=%b r=%b required v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_modes();
      logic [7:0] din  [5] = '{8'h01, 8'hC0, 8'h12, 8'h12, 8'hA5};
      logic [1:0] mds  [5] = '{2'b01, 2'b01, 2'b10, 2'b11, 2'b00};
      logic [7:0] dexp [5] = '{8'h80, 8'h03, 8'h21, 8'h84, 8'hA5};
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; in_data = din[i]; in_mode = mds[i];
         step();
         in_valid = 1'b0;
         @(negedge clk);
         total++;
         if ({out_valid, out_mode, out_data} !== {1'b1, mds[i], dexp[i]}) begin
            bad++;
            $display("FAIL mode_%0d: got v=%b m=%h d=%h required v=1 m=%h d=%h",
                     i, out_valid, out_mode, out_data, mds[i], dexp[i]);
         end
         step();
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] dexp [4] = '{8'h80, 8'h40, 8'h20, 8'h10};
      logic [7:0] w;
      out_ready = 1'b1; in_mode = 2'b01; in_valid = 1'b1; in_data = 8'h01;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i < 4) begin
            total++;
            if (in_ready !== 1'b1) begin
               bad++;
               $display("FAIL b2b_ready_%0d: got %b required 1", i, in_ready);
            end
         end
         if (i > 0) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== dexp[i-1]) begin
               bad++;
               $display("FAIL b2b_out_%0d: got v=%b d=%h required v=1 d=%h",
                        i, out_valid, out_data, dexp[i-1]);
            end
         end
         @(posedge clk); #1;
         if (i < 3) begin
            w = in_data;
            in_data = w << 1;
         end else begin
            in_valid = 1'b0;
         end
      end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0; in_mode = 2'b00; in_valid = 1'b1; in_data = 8'h11;
      step();
      in_data = 8'h22;
      step();
      in_data = 8'h33;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 8'h11}) begin
            bad++;
            $display("FAIL bp_stall_%0d: got r=%b v=%b d=%h required r=0 v=1 d=11",
                     i, in_ready, out_valid, out_data);
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      step();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h22) begin
         bad++;
         $display("FAIL bp_second: got v=%b d=%h required v=1 d=22", out_valid, out_data);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h33) begin
         bad++;
         $display("FAIL bp_third: got v=%b d=%h required v=1 d=33", out_valid, out_data);
      end
      step();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || exp_q.size() != 0) begin
         bad++;
         $display("FAIL bp_drain: got v=%b pending=%0d required v=0 pending=0", out_valid, exp_q.size());
      end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0; in_mode = 2'b00; in_valid = 1'b1; in_data = 8'h5A;
      step();
      in_data = 8'h6B;
      step();
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL rmid_full: got r=%b v=%b required r=0 v=1", in_ready, out_valid);
      end
      @(posedge clk); #1;
      resetn = 1'b0; in_data = 8'h7C;
      step();
      resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, out_data} !== {1'b0, 1'b1, 8'h00}) begin
         bad++;
         $display("FAIL rmid_flush: got v=%b r=%b d=%h required v=0 r=1 d=00", out_valid, in_ready, out_data);
      end
      for (int i = 0; i < 4; i++) begin
         step();
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL rmid_quiet_%0d: got v=%b required v=0", i, out_valid);
         end
      end
   endtask

   task automatic test_params();
      logic [1:0]  mds  [2] = '{2'b10, 2'b11};
      logic [31:0] dexp [2] = '{32'h44332211, 32'h8844CC22};
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         in_valid32 = 1'b1; in_data32 = 32'h11223344; in_mode32 = mds[i];
         step();
         in_valid32 = 1'b0;
         @(negedge clk);
         total++;
         if ({out_valid32, out_mode32, out_data32} !== {1'b1, mds[i], dexp[i]}) begin
            bad++;
            $display("FAIL w32_mode_%0d: got v=%b m=%h d=%h required v=1 m=%h d=%h",
                     i, out_valid32, out_mode32, out_data32, mds[i], dexp[i]);
         end
      end
      step();
   endtask

`ifdef VECTOR_REVERSE_PARITY_EN
   task automatic test_parity();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h07; in_mode = 2'b01;
      step();
      in_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({out_valid, out_data, out_parity} !== {1'b1, 8'hE0, 1'b1}) begin
         bad++;
         $display("FAIL parity: got v=%b d=%h p=%b required v=1 d=e0 p=1", out_valid, out_data, out_parity);
      end
      step();
   endtask
`endif

   task automatic test_random();
      acc_cnt = 0;
      out_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom);
         in_data   = 8'($urandom);
         in_mode   = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) step();
      step();
      @(negedge clk);
      total++;
      if (exp_q.size() != 0 || acc_cnt != out_cnt || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL rand_counts: got acc=%0d out=%0d pending=%0d v=%b required acc=out pending=0 v=0",
                  acc_cnt, out_cnt, exp_q.size(), out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_modes();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      test_params();
`ifdef VECTOR_REVERSE_PARITY_EN
      test_parity();
`endif
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
